dot_product_accumulator: RTL and testbench

Sequential stage directly downstream of multiplier_4bit in the matrix-multiplier datapath. It accepts a stream of 4-bit operand pairs through a valid/ready handshake and feeds each pair to one multiplier_4bit instance. It registers each 8-bit product and accumulates N products into one dot-product result, which is one element of a matrix product. Results leave through a valid/ready output port with backpressure.

---
 rtl/dot_product_accumulator_pkg.sv | 17 +
 rtl/dot_product_accumulator_multiplier.sv | 12 +
 rtl/dot_product_accumulator.sv | 129 ++++++++++++
 tb/tb_dot_product_accumulator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dot_product_accumulator_pkg.sv
// Shared constants, width helper and FSM encoding for the dot-product accumulator.
package dot_product_accumulator_pkg;

    localparam int OPW = 4;

    // Result width: full product width plus enough headroom bits to sum n products.
    function automatic int acc_width(input int n);
        return 2 * OPW + $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        LAST  = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/dot_product_accumulator_multiplier.sv
// Unsigned 4x4 combinational multiplier feeding the accumulator's product register.
module multiplier_4bit
    import dot_product_accumulator_pkg::*;
(
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    output logic [2*OPW-1:0] p
);

    assign p = (2*OPW)'(a) * (2*OPW)'(b);

endmodule

// File: rtl/dot_product_accumulator.sv
// Streams operand pairs through one multiplier, sums N registered products per
// result, and holds each result until the consumer takes it.
module dot_product_accumulator
    import dot_product_accumulator_pkg::*;
#(
    parameter  int N    = 4,
    localparam int CNTW = $clog2(N),
    localparam int ACCW = acc_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  a_in,
    input  logic [OPW-1:0]  b_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_sum
);

    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(N - 1);

    state_e            state_q, state_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [2*OPW-1:0]  prod_q, prod_d;
    logic              prod_v_q, prod_v_d;
    logic              out_valid_q, out_valid_d;
    logic [ACCW-1:0]   out_sum_q, out_sum_d;
    logic              started_q;
    logic [2*OPW-1:0]  product;
    logic              accept;

    multiplier_4bit u_mult (
        .a (a_in),
        .b (b_in),
        .p (product)
    );

    // started_q keeps in_ready low until the first edge after reset release.
    assign in_ready  = started_q && (state_q == ACCUM) && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_v_d    = 1'b0;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;

        if (accept) begin
            prod_d   = product;
            prod_v_d = 1'b1;
        end

        if (prod_v_q) begin
            acc_d = acc_q + ACCW'(prod_q);
        end

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = LAST;
                    end else begin
                        count_d = count_q + CNTW'(1);
                    end
                end
            end
            LAST: begin
                // The final product is still in prod_q, so fold it in directly.
                out_sum_d   = acc_q + ACCW'(prod_q);
                out_valid_d = 1'b1;
                acc_d       = '0;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase

        // A completed result in DONE is protected from flush.
        if (flush && (state_q != DONE)) begin
            count_d     = '0;
            acc_d       = '0;
            prod_v_d    = 1'b0;
            out_valid_d = out_valid_q;
            out_sum_d   = out_sum_q;
            state_d     = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            started_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            started_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed-vector bench for dot_product_accumulator at the default N=4.
module tb_dot_product_accumulator;

    typedef logic [3:0] vec_t [4];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] a_in = '0;
    logic [3:0] b_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] out_sum;

    int n_cmp = 0;
    int n_bad = 0;

    dot_product_accumulator #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [3:0] a, input logic [3:0] b);
        int t;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        t = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        if (t == 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_vector(input vec_t a, input vec_t b, input bit gaps, input int n);
        for (int i = 0; i < n; i++) begin
            send_pair(a[i], b[i]);
            if (gaps) step();
        end
    endtask

    task automatic wait_result(input string tag, input logic [9:0] exp);
        int t;
        t = 0;
        while (!out_valid && t < 20) begin
            step();
            t++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, 32'(out_sum), 32'(exp));
    endtask

    vec_t va, vb, v15, v0, v2, v3, v1;

    initial begin
        va  = '{4'd1, 4'd2, 4'd3, 4'd4};
        vb  = '{4'd5, 4'd6, 4'd7, 4'd8};
        v15 = '{4'd15, 4'd15, 4'd15, 4'd15};
        v0  = '{4'd0, 4'd0, 4'd0, 4'd0};
        v2  = '{4'd2, 4'd2, 4'd2, 4'd2};
        v3  = '{4'd3, 4'd3, 4'd3, 4'd3};
        v1  = '{4'd1, 4'd1, 4'd1, 4'd1};

        // Reset state
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        step();
        step();
        check("rst_held_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic vector with latency and one-cycle pulse
        send_vector(va, vb, 1'b0, 4);
        check("basic_lat_edge1", 32'(out_valid), 32'd0);
        check("basic_lat_in_ready", 32'(in_ready), 32'd0);
        step();
        check("basic_lat_edge2", 32'(out_valid), 32'd1);
        check("basic_sum", 32'(out_sum), 32'd70);
        step();
        check("basic_pulse_end", 32'(out_valid), 32'd0);
        check("basic_ready_again", 32'(in_ready), 32'd1);

        // Maximum and zero operands
        send_vector(v15, v15, 1'b0, 4);
        wait_result("max_sum", 10'd900);
        step();
        send_vector(v0, v0, 1'b0, 4);
        wait_result("zero_sum", 10'd0);
        step();

        // Bubbles in the input stream
        send_vector(va, vb, 1'b1, 4);
        wait_result("bubble_sum", 10'd70);
        step();

        // Output backpressure then back-to-back vector
        out_ready = 1'b0;
        send_vector(va, vb, 1'b0, 4);
        wait_result("bp_sum", 10'd70);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_sum", 32'(out_sum), 32'd70);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_release", 32'(out_valid), 32'd0);
        check("b2b_ready", 32'(in_ready), 32'd1);
        send_vector(v2, v3, 1'b0, 4);
        wait_result("b2b_sum", 10'd24);
        step();

        // Flush discards a partial vector
        send_vector(v15, v15, 1'b0, 2);
        flush    = 1'b1;
        in_valid = 1'b1;
        a_in     = 4'd9;
        b_in     = 4'd9;
        #1;
        check("flush_blocks_ready", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check("flush_no_result", 32'(out_valid), 32'd0);
        send_vector(v1, v1, 1'b0, 4);
        wait_result("flush_sum", 10'd4);
        step();

        // Flush while a result is held is ignored
        out_ready = 1'b0;
        send_vector(va, vb, 1'b0, 4);
        wait_result("done_flush_pre", 10'd70);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("done_flush_valid", 32'(out_valid), 32'd1);
        check("done_flush_sum", 32'(out_sum), 32'd70);
        out_ready = 1'b1;
        step();
        check("done_flush_release", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-vector
        send_vector(v15, v15, 1'b0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_sum", 32'(out_sum), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("async_post_ready", 32'(in_ready), 32'd1);
        send_vector(va, vb, 1'b0, 4);
        wait_result("async_post_sum", 10'd70);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
